// File: rtl/ysyx_22041412_ifu_fetch.sv
// Instruction fetch: owns the PC, fills a one-line buffer from the icache, and feeds decode one 32-bit instruction per cycle.
// Latency: a hit is presented combinationally from registers; a line returned in cycle t is presented at t+1.
// Backpressure: out_valid/out_ready handshake; while out_ready is low the PC and the presented instruction hold.
module ysyx_22041412_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,            // asynchronous, active-low
  input  logic         redirect_valid_i,
  input  logic [31:0]  redirect_pc_i,
  input  logic         fence_i_req_i,
  output logic         fence_i_done_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_pc_o,
  output logic [31:0]  out_inst_o,
  output logic [31:0]  ic_req_addr_o,
  output logic         ic_valid_o,
  input  logic [127:0] ic_read_data_i,
  input  logic         ic_ready_i,
  output logic         ic_read_vaild_o,
  output logic         ic_read_clean_o,
  input  logic         ic_cache_clear_i,
  output logic         ic_fence_i_o,
  input  logic         ic_fence_ready_i,
  output logic [63:0]  perf_inst_cnt_o,
  output logic [63:0]  perf_stall_cnt_o
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    REQ        = 3'd1,
    DISCARD    = 3'd2,
    FENCE      = 3'd3,
    FENCE_WAIT = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          lb_valid_q, lb_valid_d;
  logic [27:0]   lb_tag_q, lb_tag_d;
  logic [127:0]  lb_data_q, lb_data_d;
  logic          fence_pend_q, fence_pend_d;
  logic [63:0]   inst_cnt_q, stall_cnt_q;

  logic          hit;
  logic          fire;
  logic [31:0]   redir_pc;

  // Redirect targets are always word aligned.
  assign redir_pc = redirect_pc_i & 32'hFFFF_FFFC;

  assign hit         = lb_valid_q && (lb_tag_q == pc_q[31:4]);
  assign out_valid_o = hit && (state_q == RUN) && !redirect_valid_i && !fence_pend_q;
  assign fire        = out_valid_o && out_ready_i;

  assign out_pc_o      = pc_q;
  assign ic_req_addr_o = {pc_q[31:4], 4'b0000};

  assign perf_inst_cnt_o  = inst_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;

  // Select the word of the buffered line addressed by pc[3:2].
  always_comb begin
    out_inst_o = lb_data_q[31:0];
    case (pc_q[3:2])
      2'd0: out_inst_o = lb_data_q[31:0];
      2'd1: out_inst_o = lb_data_q[63:32];
      2'd2: out_inst_o = lb_data_q[95:64];
      2'd3: out_inst_o = lb_data_q[127:96];
      default: out_inst_o = lb_data_q[31:0];
    endcase
  end

  // Next-state, PC/line-buffer update and icache handshake outputs.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    lb_valid_d      = lb_valid_q;
    lb_tag_d        = lb_tag_q;
    lb_data_d       = lb_data_q;
    fence_pend_d    = fence_pend_q | fence_i_req_i;
    ic_valid_o      = 1'b0;
    ic_read_vaild_o = 1'b0;
    ic_read_clean_o = 1'b0;
    ic_fence_i_o    = 1'b0;
    fence_i_done_o  = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect_valid_i) begin
          pc_d = redir_pc;
        end else if (fire) begin
          pc_d = pc_q + 32'd4;
        end
        // A redirect keeps the line buffer; the new PC is tested next cycle.
        if (fence_pend_q) begin
          state_d = FENCE;
        end else if (!redirect_valid_i && !hit) begin
          state_d = REQ;
        end
      end
      REQ: begin
        ic_valid_o = 1'b1;
        if (redirect_valid_i) begin
          // The returning line belongs to the old path: drop it.
          pc_d    = redir_pc;
          state_d = DISCARD;
        end else if (ic_ready_i) begin
          ic_read_vaild_o = 1'b1;
          lb_valid_d      = 1'b1;
          lb_tag_d        = pc_q[31:4];
          lb_data_d       = ic_read_data_i;
          state_d         = RUN;
        end
      end
      DISCARD: begin
        ic_read_clean_o = 1'b1;
        if (redirect_valid_i) begin
          pc_d = redir_pc;
        end
        if (ic_cache_clear_i && !ic_ready_i) begin
          state_d = RUN;
        end
      end
      FENCE: begin
        ic_fence_i_o = 1'b1;
        lb_valid_d   = 1'b0;
        fence_pend_d = fence_i_req_i;
        if (redirect_valid_i) begin
          pc_d = redir_pc;
        end
        state_d = FENCE_WAIT;
      end
      FENCE_WAIT: begin
        if (redirect_valid_i) begin
          pc_d = redir_pc;
        end
        if (ic_fence_ready_i) begin
          fence_i_done_o = 1'b1;
          state_d        = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, PC and line-buffer registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      lb_valid_q   <= 1'b0;
      lb_tag_q     <= 28'd0;
      lb_data_q    <= 128'd0;
      fence_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      lb_valid_q   <= lb_valid_d;
      lb_tag_q     <= lb_tag_d;
      lb_data_q    <= lb_data_d;
      fence_pend_q <= fence_pend_d;
    end
  end

  // Performance counters: retired-to-decode instructions and decode starvation cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inst_cnt_q  <= 64'd0;
      stall_cnt_q <= 64'd0;
    end else begin
      if (fire) begin
        inst_cnt_q <= inst_cnt_q + 64'd1;
      end
      if (out_ready_i && !out_valid_o) begin
        stall_cnt_q <= stall_cnt_q + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_ifu_fetch.sv
// Directed bench for the fetch unit: reset, line fill, backpressure, redirects, fence.i, async reset.
// Latency: checks sample 1 ns after the rising edge or after input changes settle.
// Backpressure: decode readiness is driven explicitly per scenario.
module tb_ysyx_22041412_ifu_fetch;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         redirect_valid_i;
  logic [31:0]  redirect_pc_i;
  logic         fence_i_req_i;
  logic         fence_i_done_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [31:0]  out_pc_o;
  logic [31:0]  out_inst_o;
  logic [31:0]  ic_req_addr_o;
  logic         ic_valid_o;
  logic [127:0] ic_read_data_i;
  logic         ic_ready_i;
  logic         ic_read_vaild_o;
  logic         ic_read_clean_o;
  logic         ic_cache_clear_i;
  logic         ic_fence_i_o;
  logic         ic_fence_ready_i;
  logic [63:0]  perf_inst_cnt_o;
  logic [63:0]  perf_stall_cnt_o;

  int checks = 0;
  int failures = 0;

  ysyx_22041412_ifu_fetch dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .fence_i_req_i    (fence_i_req_i),
    .fence_i_done_o   (fence_i_done_o),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_pc_o         (out_pc_o),
    .out_inst_o       (out_inst_o),
    .ic_req_addr_o    (ic_req_addr_o),
    .ic_valid_o       (ic_valid_o),
    .ic_read_data_i   (ic_read_data_i),
    .ic_ready_i       (ic_ready_i),
    .ic_read_vaild_o  (ic_read_vaild_o),
    .ic_read_clean_o  (ic_read_clean_o),
    .ic_cache_clear_i (ic_cache_clear_i),
    .ic_fence_i_o     (ic_fence_i_o),
    .ic_fence_ready_i (ic_fence_ready_i),
    .perf_inst_cnt_o  (perf_inst_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ic_valid();
    int n;
    n = 0;
    while (!ic_valid_o && n < 20) begin
      step();
      n++;
    end
    chk("ic_valid_seen", {63'd0, ic_valid_o}, 64'd1);
  endtask

  // Icache side: accept the request, hold it for 'dly' cycles, return 'line' for one cycle.
  task automatic serve_line(input logic [31:0] addr, input logic [127:0] line, input int dly);
    wait_ic_valid();
    chk("req_addr", {32'd0, ic_req_addr_o}, {32'd0, addr});
    for (int i = 0; i < dly; i++) begin
      step();
      chk("req_hold_vld", {63'd0, ic_valid_o}, 64'd1);
      chk("req_hold_addr", {32'd0, ic_req_addr_o}, {32'd0, addr});
    end
    ic_ready_i     = 1'b1;
    ic_read_data_i = line;
    #1;
    chk("read_vaild", {63'd0, ic_read_vaild_o}, 64'd1);
    step();
    ic_ready_i = 1'b0;
    #1;
  endtask

  logic [127:0] line0, line1, line2, junk;
  logic [31:0]  wexp [8];
  logic [63:0]  snap_s, snap_i;
  int           nf, nd;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    line0 = 128'h33333333_22222222_11111111_00000000;
    line1 = 128'h77777777_66666666_55555555_44444444;
    line2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    junk  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    wexp  = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
              32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};

    rst_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'd0; fence_i_req_i = 1'b0;
    out_ready_i = 1'b0; ic_read_data_i = 128'd0; ic_ready_i = 1'b0;
    ic_cache_clear_i = 1'b0; ic_fence_ready_i = 1'b0;

    // Reset values
    step(); step();
    chk("rst_ic_valid", {63'd0, ic_valid_o}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_req_addr", {32'd0, ic_req_addr_o}, 64'h8000_0000);
    chk("rst_out_pc", {32'd0, out_pc_o}, 64'h8000_0000);
    chk("rst_fence_i", {63'd0, ic_fence_i_o}, 64'd0);
    chk("rst_clean", {63'd0, ic_read_clean_o}, 64'd0);
    chk("rst_done", {63'd0, fence_i_done_o}, 64'd0);
    chk("rst_inst_cnt", perf_inst_cnt_o, 64'd0);
    chk("rst_stall_cnt", perf_stall_cnt_o, 64'd0);

    // First fetch: RUN detects the miss, REQ from the next cycle
    rst_i = 1'b1;
    #1;
    chk("first_no_req_yet", {63'd0, ic_valid_o}, 64'd0);
    step();
    chk("first_req_cycle2", {63'd0, ic_valid_o}, 64'd1);
    serve_line(32'h8000_0000, line0, 2);
    out_ready_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_valid", {63'd0, out_valid_o}, 64'd1);
      chk("seq_pc", {32'd0, out_pc_o}, {32'd0, 32'h8000_0000 + 32'(4 * i)});
      chk("seq_inst", {32'd0, out_inst_o}, {32'd0, wexp[i]});
      step();
    end
    chk("boundary_miss_valid", {63'd0, out_valid_o}, 64'd0);
    chk("boundary_gap", {63'd0, ic_valid_o}, 64'd0);
    chk("inst_cnt_4", perf_inst_cnt_o, 64'd4);
    snap_s = perf_stall_cnt_o;
    step(); step(); step();
    chk("stall_cnt_delta", perf_stall_cnt_o, snap_s + 64'd3);
    out_ready_i = 1'b0;

    // Second line, then decode backpressure
    serve_line(32'h8000_0010, line1, 1);
    out_ready_i = 1'b1;
    #1;
    chk("l1_pc0", {32'd0, out_pc_o}, 64'h8000_0010);
    chk("l1_inst0", {32'd0, out_inst_o}, {32'd0, wexp[4]});
    step();
    out_ready_i = 1'b0;
    #1;
    snap_i = perf_inst_cnt_o;
    snap_s = perf_stall_cnt_o;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {63'd0, out_valid_o}, 64'd1);
      chk("bp_pc", {32'd0, out_pc_o}, 64'h8000_0014);
      chk("bp_inst", {32'd0, out_inst_o}, {32'd0, wexp[5]});
      step();
    end
    chk("bp_inst_cnt", perf_inst_cnt_o, 64'd5);
    chk("bp_inst_frozen", perf_inst_cnt_o, snap_i);
    chk("bp_stall_frozen", perf_stall_cnt_o, snap_s);

    // Redirect within the buffered line (low bits of target ignored)
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_001F;
    #1;
    chk("redir_blocks_valid", {63'd0, out_valid_o}, 64'd0);
    step();
    redirect_valid_i = 1'b0;
    #1;
    chk("redir_no_req", {63'd0, ic_valid_o}, 64'd0);
    chk("redir_valid", {63'd0, out_valid_o}, 64'd1);
    chk("redir_pc", {32'd0, out_pc_o}, 64'h8000_001C);
    chk("redir_inst", {32'd0, out_inst_o}, {32'd0, wexp[7]});
    out_ready_i = 1'b1;
    #1;
    step();
    out_ready_i = 1'b0;
    #1;
    chk("inst_cnt_6", perf_inst_cnt_o, 64'd6);
    chk("l2_miss_valid", {63'd0, out_valid_o}, 64'd0);
    step();
    chk("l2_req", {63'd0, ic_valid_o}, 64'd1);
    chk("l2_req_addr", {32'd0, ic_req_addr_o}, 64'h8000_0020);

    // Redirect in the same cycle as ic_ready: line must be dropped
    step();
    ic_ready_i       = 1'b1;
    ic_read_data_i   = junk;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_1000;
    #1;
    chk("drop_vaild", {63'd0, ic_read_vaild_o}, 64'd0);
    step();
    ic_ready_i       = 1'b0;
    redirect_valid_i = 1'b0;
    #1;
    chk("discard_clean", {63'd0, ic_read_clean_o}, 64'd1);
    chk("discard_no_req", {63'd0, ic_valid_o}, 64'd0);
    step();
    chk("discard_hold", {63'd0, ic_read_clean_o}, 64'd1);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_001C;
    step();
    redirect_valid_i = 1'b0;
    #1;
    chk("discard_redir_stay", {63'd0, ic_read_clean_o}, 64'd1);
    ic_cache_clear_i = 1'b1;
    step();
    ic_cache_clear_i = 1'b0;
    #1;
    chk("clear_clean_off", {63'd0, ic_read_clean_o}, 64'd0);
    chk("lb_kept_valid", {63'd0, out_valid_o}, 64'd1);
    chk("lb_kept_pc", {32'd0, out_pc_o}, 64'h8000_001C);
    chk("lb_kept_inst", {32'd0, out_inst_o}, {32'd0, wexp[7]});
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_1000;
    step();
    redirect_valid_i = 1'b0;
    #1;
    chk("far_miss_valid", {63'd0, out_valid_o}, 64'd0);
    chk("far_gap", {63'd0, ic_valid_o}, 64'd0);
    step();
    chk("far_req", {63'd0, ic_valid_o}, 64'd1);
    chk("far_req_addr", {32'd0, ic_req_addr_o}, 64'h8000_1000);

    // fence.i during REQ: the fill completes first, then one invalidate pulse
    fence_i_req_i = 1'b1;
    step();
    fence_i_req_i = 1'b0;
    #1;
    serve_line(32'h8000_1000, line2, 1);
    chk("fence_pend_blocks", {63'd0, out_valid_o}, 64'd0);
    chk("fence_not_yet", {63'd0, ic_fence_i_o}, 64'd0);
    step();
    chk("fence_pulse", {63'd0, ic_fence_i_o}, 64'd1);
    chk("fence_no_req", {63'd0, ic_valid_o}, 64'd0);
    nf = 0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      nf += int'(ic_fence_i_o);
      nd += int'(fence_i_done_o);
    end
    chk("fence_single_pulse", 64'(nf), 64'd0);
    chk("fence_done_early", 64'(nd), 64'd0);
    ic_fence_ready_i = 1'b1;
    #1;
    chk("fence_done", {63'd0, fence_i_done_o}, 64'd1);
    step();
    ic_fence_ready_i = 1'b0;
    #1;
    chk("fence_done_once", {63'd0, fence_i_done_o}, 64'd0);
    chk("fence_lb_invalid", {63'd0, out_valid_o}, 64'd0);
    step();
    chk("refetch_req", {63'd0, ic_valid_o}, 64'd1);
    chk("refetch_addr", {32'd0, ic_req_addr_o}, 64'h8000_1000);

    // Asynchronous reset mid-request, observed before the next edge
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_ic_valid", {63'd0, ic_valid_o}, 64'd0);
    chk("arst_req_addr", {32'd0, ic_req_addr_o}, 64'h8000_0000);
    chk("arst_out_pc", {32'd0, out_pc_o}, 64'h8000_0000);
    chk("arst_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("arst_clean", {63'd0, ic_read_clean_o}, 64'd0);
    chk("arst_inst_cnt", perf_inst_cnt_o, 64'd0);
    chk("arst_stall_cnt", perf_stall_cnt_o, 64'd0);
    step();
    rst_i = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_ifu_fetch.md
# ysyx_22041412_ifu_fetch

Instruction fetch unit sitting directly upstream of the 4-way instruction cache. Owns the PC, issues line requests to the icache, holds the returned 128-bit line in a one-entry line buffer, and hands 32-bit instructions with their PC to decode. It also handles redirects from execute (with icache request discard) and sequences `fence.i` into the icache.

## Interface
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `redirect_valid` in 1: branch/jump/trap redirect, single-cycle pulse.
- `redirect_pc` in 32: new PC; bits [1:0] forced to 00.
- `fence_i_req` in 1: `fence.i` request pulse from execute.
- `fence_i_done` out 1: one-cycle pulse when icache invalidation completes.
- `out_valid` out 1: `out_inst`/`out_pc` valid to decode.
- `out_ready` in 1: decode accepts; fire = `out_valid & out_ready`.
- `out_pc` out 32, `out_inst` out 32.
- `ic_req_addr` out 32: `{pc[31:4],4'b0}`.
- `ic_valid` out 1: request to icache.
- `ic_read_data` in 128, `ic_ready` in 1: line returned.
- `ic_read_vaild` out 1: line accepted.
- `ic_read_clean` out 1: discard the outstanding request.
- `ic_cache_clear` in 1: icache reports the discard is done or it is idle.
- `ic_fence_i` out 1: invalidate pulse to icache.
- `ic_fence_ready` in 1: icache invalidation done.
- `perf_inst_cnt` out 64: fires counted.
- `perf_stall_cnt` out 64: cycles with `out_ready & ~out_valid`.

## Operation
- **State:** `pc`[31:0], `lb_valid`, `lb_tag`[27:0], `lb_data`[127:0], `fence_pend`.
- **FSM:** RUN, REQ, DISCARD, FENCE, FENCE_WAIT.
- **Hit:** `lb_valid & lb_tag==pc[31:4]`.
- `out_inst = lb_data[32*pc[3:2] +: 32]`.
- `out_pc = pc`.
- `out_valid = hit & state==RUN & ~redirect_valid & ~fence_pend`.
- **RUN:**
  - Fire: `pc <= pc+4`. Wrap from 32'hFFFF_FFFC to 0.
  - Miss with no fence pending: go to REQ.
  - `fence_pend` set: go to FENCE.
- **REQ:**
  - Hold `ic_valid=1`; `ic_req_addr` stays stable.
  - `ic_ready=1`: `ic_read_vaild=1` that cycle (combinational); load `lb_data`/`lb_tag`; set `lb_valid`; go to RUN.
- **Redirect:**
  - Any state: `pc <= redirect_pc`.
  - In RUN, `lb` is kept, so the new PC may hit.
  - In REQ, go to DISCARD, even if `ic_ready` is high the same cycle. The line is dropped and `ic_read_vaild` stays 0.
- **DISCARD:**
  - `ic_valid=0`, `ic_read_clean=1`.
  - `ic_cache_clear=1` with `ic_ready=0`: go to RUN.
  - Further redirects only update `pc`.
- **Fence:**
  - `fence_i_req` sets `fence_pend` in any state.
  - Taken only from RUN, so a REQ or DISCARD in flight completes first.
  - FENCE (one cycle): `ic_fence_i=1`, `lb_valid<=0`, `fence_pend<=0`; go to FENCE_WAIT.
  - FENCE_WAIT: on `ic_fence_ready`, `fence_i_done=1` for one cycle, then go to RUN.
- `fence_i_req` and `redirect_valid` in the same cycle: both take effect.
- Perf counters wrap modulo 2^64 and are cleared only by reset.

## Timing
- **Reset values:**
  - `pc`=`RESET_PC`, state RUN, `lb_valid`=0, `fence_pend`=0.
  - All 1-bit outputs 0; `ic_req_addr`={RESET_PC[31:4],0}; perf counters 0.
- **First request:** cycle 1 after reset release detects the miss; REQ with `ic_valid=1` from cycle 2.
- **Hit path:** `out_valid` is combinational from registers, so one instruction per cycle within a line.
- **Line fill:** `ic_ready` seen in cycle t → `out_valid` at t+1.
  - Icache hit: ≥2 cycles after `ic_valid` rises.
  - Icache miss: bounded by the AXI 2-beat burst.
- **Request gap:** `ic_valid` is low for ≥1 cycle between consecutive requests and before `ic_fence_i`. This guarantees the icache sits in idle and `ic_ready` has dropped.
- **Line boundary:** fire at `pc[3:2]==3` → next cycle miss → REQ the cycle after. Sequential line crossing costs ≥4 bubble cycles.
- **Reset mid-request:** state returns to RUN immediately; `ic_valid` drops with no discard handshake.
- **Output stability:** `out_pc`/`out_inst` are stable while `out_valid & ~out_ready`, unless a redirect arrives.

## Test plan
- **Reset and first fetch:** reset released, icache returns line {W3,W2,W1,W0} for 0x80000000.
  - `ic_req_addr`=0x80000000 only.
  - With `out_ready=1`: `out_pc` 0x80000000..0x8000000C on consecutive cycles with `out_inst` W0..W3.
  - Then a new REQ at 0x80000010.
- **Decode backpressure:** `out_ready=0` for 5 cycles at pc 0x80000004 → `out_pc`/`out_inst` hold, `perf_inst_cnt` frozen, `perf_stall_cnt` unchanged.
- **Redirect within line:** redirect to 0x80000008 while in RUN with a buffered line → no `ic_valid`; next `out_pc`=0x80000008.
- **Redirect during REQ:** redirect to 0x80001000 in the same cycle as `ic_ready` → `ic_read_clean=1`, `ic_read_vaild=0`, `lb` unchanged.
  - After `ic_cache_clear`, REQ to 0x80001000.
- **Fence during REQ:** `fence_i_req` during REQ → line completes, then `ic_fence_i` pulses once.
  - `ic_fence_ready` 20 cycles later → `fence_i_done` pulses once, `lb_valid`=0.
  - Refetch at the current pc.
- **Asynchronous reset mid-flight:** assert `rst=0` mid-REQ → all outputs are at reset values before the next clock edge.
